cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Parametrised common-data-bus arbiter.
- Collects completion results from NUM_REQ execution units on exu2cdb-style req/rdy channels.
- Broadcasts up to NUM_CDB results per cycle on cdb-style write lanes to the ROB, reservation stations and RAT.
- Successor to the single-lane CDB: one skid entry per source, round-robin fairness, multi-lane broadcast, flush support.

Parameters:
- NUM_REQ, 4, number of execution-unit source channels (2..8).
- NUM_CDB, 2, number of broadcast lanes (1..NUM_REQ).
- TAG_W, 4, tag width.
- ROB_DEPTH, 16, ROB entries.
- ROB_PTR_W, $clog2(ROB_DEPTH), inst_id width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush from ROB; discard all pending results.
- exu_req  in  NUM_REQ  per-source result valid.
- exu_rdy  out  NUM_REQ  per-source accept.
- exu_tag  in  NUM_REQ*TAG_W  per-source tag.
- exu_wdata  in  NUM_REQ*32  per-source result data.
- exu_inst_id  in  NUM_REQ*ROB_PTR_W  per-source ROB id.
- cdb_wr  out  NUM_CDB  per-lane broadcast valid.
- cdb_tag  out  NUM_CDB*TAG_W  per-lane tag.
- cdb_wdata  out  NUM_CDB*32  per-lane data.
- cdb_inst_id  out  NUM_CDB*ROB_PTR_W  per-lane ROB id.

Behaviour:
- Reset (async, rst_n=0): all skid entries invalid, rr_ptr=0, cdb_wr=0, cdb_tag/wdata/inst_id=0. exu_rdy becomes 1 for all sources once flush=0.
- Skid entry per source i: {vld, tag, wdata, inst_id}.
- exu_rdy[i] = ~flush & (~vld[i] | gnt[i]). It depends only on state and grant, never on exu_req.
- Transfer when exu_req[i] & exu_rdy[i]; the entry is loaded at the next edge. A granted-and-refilled entry stays valid with the new payload.
- Arbitration is combinational over vld[] each cycle:
  - Scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Grant the first NUM_CDB valid entries.
  - The k-th grant in scan order drives lane k.
  - Granted entries clear at the edge unless refilled.
- Outputs are registered: lane k shows the granted entry on the cycle after the grant. Unused lanes drive cdb_wr=0 and hold the previous payload.
- Latency: exu_req accepted at cycle T, grant at T+1, cdb_wr at T+2 minimum. Full throughput: one result per source per cycle when lanes are available.
- rr_ptr update:
  - If any grant: rr_ptr = (index of last granted source + 1) mod NUM_REQ.
  - Otherwise rr_ptr is unchanged.
  - Guarantees each valid entry is granted within ceil(NUM_REQ/NUM_CDB) cycles.
- Flush:
  - At the next edge all vld=0 and cdb_wr=0.
  - Requests presented during the flush cycle are not accepted (rdy=0).
  - rr_ptr is held.
  - A broadcast already registered before flush still appears in the flush cycle; consumers qualify it.
- Simultaneous flush and rst_n=0: reset dominates.
- Reset mid-operation: pending entries are lost with no broadcast.
- NUM_CDB=NUM_REQ: every valid entry is granted each cycle, with no stall.

Optional Feature:
- Macro CDB_ARB_PERF_EN.
- When defined, add outputs perf_stall_cnt (NUM_REQ*32) and perf_bcast_cnt (32), both reset to 0 and cleared only by reset, saturating at all-ones:
  - perf_stall_cnt[i] increments each cycle exu_req[i]=1 and exu_rdy[i]=0.
  - perf_bcast_cnt adds popcount(cdb_wr) each cycle.
- Without the macro: no ports, no counter logic, identical functional behaviour.

Decomposition:
- Package cdb_pkg holds:
  - typedef cdb_entry_t {tag, wdata, inst_id}, parameterised via the package constants TAG_W and ROB_PTR_W.
  - localparams for default NUM_REQ and NUM_CDB.
- One sub-module: rr_multi_picker. Inputs vld[NUM_REQ] and rr_ptr; outputs gnt[NUM_REQ], per-lane source index, lane valid, and next rr_ptr. Purely combinational and reusable by the reservation-station issue select.

Test Plan:
1. Single source: exu_req[0]=1 for one cycle with tag=3, wdata=32'hDEAD_BEEF, inst_id=5 -> cdb_wr[0]=1 two cycles later with the same payload; cdb_wr[1]=0.
2. Contention, NUM_REQ=4, NUM_CDB=2: all four request in the same cycle, rr_ptr=0 -> first broadcast lanes carry sources 0,1; next cycle sources 2,3; rr_ptr returns to 0; exu_rdy[2,3]=0 for one cycle.
3. Back-to-back streaming: source 1 holds exu_req=1 for 10 cycles with incrementing wdata -> exu_rdy[1] stays 1 and 10 consecutive broadcasts arrive in order, with no gaps.
4. Flush: two entries valid and flush=1 -> next cycle cdb_wr=0, all vld=0, exu_rdy=0 during the flush cycle and 1 after; rr_ptr unchanged.
5. Async reset asserted mid-stream, off-edge -> cdb_wr=0 immediately; after release, exu_rdy=all 1s and no stale broadcast appears.
6. With CDB_ARB_PERF_EN, scenario 2 -> perf_stall_cnt[2]=perf_stall_cnt[3]=1 if the requests are held, and perf_bcast_cnt=4.

Source files
------------

// File: rtl/cdb_pkg.sv
// ---------------------------------------------------------------------------
// cdb_pkg
// Shared types and constants for the common-data-bus arbiter and related
// blocks (reservation-station issue select, ROB write-back).
//   TAG_W / ROB_DEPTH / ROB_PTR_W : default payload widths
//   DEF_NUM_REQ / DEF_NUM_CDB     : default source and lane counts
//   cdb_entry_t                   : one completion result {tag, wdata, inst_id}
// ---------------------------------------------------------------------------
package cdb_pkg;

  localparam int TAG_W       = 4;
  localparam int ROB_DEPTH   = 16;
  localparam int ROB_PTR_W   = $clog2(ROB_DEPTH);
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_NUM_CDB = 2;

  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    logic [31:0]          wdata;
    logic [ROB_PTR_W-1:0] inst_id;
  } cdb_entry_t;

endpackage

// File: rtl/rr_multi_picker.sv
// ---------------------------------------------------------------------------
// rr_multi_picker
// Purely combinational round-robin picker that selects up to NUM_CDB
// requesters per cycle. The scan starts at rr_ptr and wraps modulo NUM_REQ;
// the k-th hit in scan order is assigned to lane k.
// Ports:
//   vld         in  NUM_REQ           candidate valid flags
//   rr_ptr      in  IDX_W             scan start index
//   gnt         out NUM_REQ           one-hot-per-winner grant vector
//   lane_src    out NUM_CDB x IDX_W   source index driving each lane
//   lane_vld    out NUM_CDB           lane carries a grant this cycle
//   rr_ptr_next out IDX_W             one past the last winner (or rr_ptr)
// ---------------------------------------------------------------------------
module rr_multi_picker
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int NUM_CDB = DEF_NUM_CDB,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]            vld,
  input  logic [IDX_W-1:0]              rr_ptr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_CDB-1:0][IDX_W-1:0] lane_src,
  output logic [NUM_CDB-1:0]            lane_vld,
  output logic [IDX_W-1:0]              rr_ptr_next
);

  always_comb begin
    int idx;
    int cnt;
    gnt         = '0;
    lane_src    = '0;
    lane_vld    = '0;
    rr_ptr_next = rr_ptr;
    idx         = 0;
    cnt         = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (vld[idx] && (cnt < NUM_CDB)) begin
        gnt[idx]      = 1'b1;
        lane_src[cnt] = IDX_W'(idx);
        lane_vld[cnt] = 1'b1;
        // Pointer lands just past the most recent winner, so the next scan
        // begins with the first source that lost this round.
        rr_ptr_next   = IDX_W'((idx + 1) % NUM_REQ);
        cnt           = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Common-data-bus arbiter: one skid entry per execution-unit source,
// round-robin selection of up to NUM_CDB entries per cycle, registered
// multi-lane broadcast to ROB / reservation stations / RAT, flush support.
// Optional build macro: CDB_ARB_PERF_EN adds saturating performance counters.
// Ports:
//   clk, rst_n     clock / asynchronous active-low reset
//   flush          discard all pending results, block acceptance this cycle
//   exu_req/rdy    per-source result handshake (rdy independent of req)
//   exu_tag/wdata/inst_id  per-source payload, packed source-major
//   cdb_wr         per-lane broadcast valid (registered)
//   cdb_tag/wdata/inst_id  per-lane payload (registered, held when idle)
//   perf_stall_cnt (CDB_ARB_PERF_EN) per-source cycles with req & ~rdy
//   perf_bcast_cnt (CDB_ARB_PERF_EN) total broadcasts issued
// ---------------------------------------------------------------------------
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int NUM_CDB   = DEF_NUM_CDB,
  parameter int TAG_W     = cdb_pkg::TAG_W,
  parameter int ROB_DEPTH = cdb_pkg::ROB_DEPTH,
  parameter int ROB_PTR_W = $clog2(ROB_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             exu_req,
  output logic [NUM_REQ-1:0]             exu_rdy,
  input  logic [NUM_REQ*TAG_W-1:0]       exu_tag,
  input  logic [NUM_REQ*32-1:0]          exu_wdata,
  input  logic [NUM_REQ*ROB_PTR_W-1:0]   exu_inst_id,
  output logic [NUM_CDB-1:0]             cdb_wr,
  output logic [NUM_CDB*TAG_W-1:0]       cdb_tag,
  output logic [NUM_CDB*32-1:0]          cdb_wdata,
  output logic [NUM_CDB*ROB_PTR_W-1:0]   cdb_inst_id
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]          perf_stall_cnt,
  output logic [31:0]                    perf_bcast_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                vld;
  logic [NUM_REQ-1:0][TAG_W-1:0]     ent_tag;
  logic [NUM_REQ-1:0][31:0]          ent_wdata;
  logic [NUM_REQ-1:0][ROB_PTR_W-1:0] ent_inst_id;

  logic [NUM_REQ-1:0]                gnt;
  logic [NUM_CDB-1:0][IDX_W-1:0]     lane_src;
  logic [NUM_CDB-1:0]                lane_vld;
  logic [IDX_W-1:0]                  rr_ptr_reg;
  logic [IDX_W-1:0]                  rr_ptr_next;

  rr_multi_picker #(
    .NUM_REQ (NUM_REQ),
    .NUM_CDB (NUM_CDB),
    .IDX_W   (IDX_W)
  ) u_picker (
    .vld         (vld),
    .rr_ptr      (rr_ptr_reg),
    .gnt         (gnt),
    .lane_src    (lane_src),
    .lane_vld    (lane_vld),
    .rr_ptr_next (rr_ptr_next)
  );

  // An entry can take a new result when empty or when it is being drained
  // this cycle, which gives one result per source per cycle while granted.
  assign exu_rdy = ~{NUM_REQ{flush}} & (~vld | gnt);

  // ---- per-source skid entries ----
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
    logic                 vld_reg;
    logic [TAG_W-1:0]     tag_reg;
    logic [31:0]          wdata_reg;
    logic [ROB_PTR_W-1:0] inst_id_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_reg     <= 1'b0;
        tag_reg     <= '0;
        wdata_reg   <= '0;
        inst_id_reg <= '0;
      end else if (flush) begin
        vld_reg     <= 1'b0;
      end else if (exu_req[gi] && exu_rdy[gi]) begin
        // Refill wins over the grant-clear: the entry stays valid.
        vld_reg     <= 1'b1;
        tag_reg     <= exu_tag[gi*TAG_W +: TAG_W];
        wdata_reg   <= exu_wdata[gi*32 +: 32];
        inst_id_reg <= exu_inst_id[gi*ROB_PTR_W +: ROB_PTR_W];
      end else if (gnt[gi]) begin
        vld_reg     <= 1'b0;
      end
    end

    assign vld[gi]         = vld_reg;
    assign ent_tag[gi]     = tag_reg;
    assign ent_wdata[gi]   = wdata_reg;
    assign ent_inst_id[gi] = inst_id_reg;
  end

  // ---- round-robin pointer (held across flush) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
    end else if (!flush && (|gnt)) begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // ---- registered broadcast lanes ----
  for (genvar gi = 0; gi < NUM_CDB; gi++) begin : g_lane
    logic                 wr_reg;
    logic [TAG_W-1:0]     tag_reg;
    logic [31:0]          wdata_reg;
    logic [ROB_PTR_W-1:0] inst_id_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_reg      <= 1'b0;
        tag_reg     <= '0;
        wdata_reg   <= '0;
        inst_id_reg <= '0;
      end else begin
        wr_reg <= lane_vld[gi] & ~flush;
        // Idle lanes keep their last payload to avoid needless toggling.
        if (lane_vld[gi] && !flush) begin
          tag_reg     <= ent_tag[lane_src[gi]];
          wdata_reg   <= ent_wdata[lane_src[gi]];
          inst_id_reg <= ent_inst_id[lane_src[gi]];
        end
      end
    end

    assign cdb_wr[gi]                              = wr_reg;
    assign cdb_tag[gi*TAG_W +: TAG_W]              = tag_reg;
    assign cdb_wdata[gi*32 +: 32]                  = wdata_reg;
    assign cdb_inst_id[gi*ROB_PTR_W +: ROB_PTR_W]  = inst_id_reg;
  end

`ifdef CDB_ARB_PERF_EN
  // ---- saturating performance counters, cleared only by reset ----
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
    logic [31:0] stall_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stall_reg <= '0;
      end else if (exu_req[gi] && !exu_rdy[gi] && (stall_reg != '1)) begin
        stall_reg <= stall_reg + 32'd1;
      end
    end

    assign perf_stall_cnt[gi*32 +: 32] = stall_reg;
  end

  logic [31:0] bcast_reg;
  logic [32:0] bcast_sum;

  assign bcast_sum = {1'b0, bcast_reg} + 33'($countones(cdb_wr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcast_reg <= '0;
    end else begin
      bcast_reg <= bcast_sum[32] ? '1 : bcast_sum[31:0];
    end
  end

  assign perf_bcast_cnt = bcast_reg;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed bench for cdb_arbiter (NUM_REQ=4, NUM_CDB=2). Expected broadcasts
// are queued in the order they must appear (lane 0 before lane 1, then next
// cycle); a negedge monitor pops and compares every asserted lane.
// Optional build macro: CDB_ARB_PERF_EN also checks the perf counters.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NR = 4;
  localparam int NC = 2;
  localparam int TW = TAG_W;
  localparam int IW = ROB_PTR_W;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic [NR-1:0]     exu_req = '0;
  logic [NR-1:0]     exu_rdy;
  logic [NR*TW-1:0]  exu_tag = '0;
  logic [NR*32-1:0]  exu_wdata = '0;
  logic [NR*IW-1:0]  exu_inst_id = '0;
  logic [NC-1:0]     cdb_wr;
  logic [NC*TW-1:0]  cdb_tag;
  logic [NC*32-1:0]  cdb_wdata;
  logic [NC*IW-1:0]  cdb_inst_id;
`ifdef CDB_ARB_PERF_EN
  logic [NR*32-1:0]  perf_stall_cnt;
  logic [31:0]       perf_bcast_cnt;
`endif

  cdb_entry_t sb[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(NR), .NUM_CDB(NC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .exu_req     (exu_req),
    .exu_rdy     (exu_rdy),
    .exu_tag     (exu_tag),
    .exu_wdata   (exu_wdata),
    .exu_inst_id (exu_inst_id),
    .cdb_wr      (cdb_wr),
    .cdb_tag     (cdb_tag),
    .cdb_wdata   (cdb_wdata),
    .cdb_inst_id (cdb_inst_id)
`ifdef CDB_ARB_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_bcast_cnt (perf_bcast_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic cdb_entry_t mk(input int i, input int base);
    cdb_entry_t e;
    e.tag     = TW'(i + base);
    e.wdata   = 32'hA500_0000 + 32'(base * 16 + i);
    e.inst_id = IW'(i + 3 * base);
    return e;
  endfunction

  task automatic drive(input int i, input cdb_entry_t e);
    exu_req[i]                = 1'b1;
    exu_tag[i*TW +: TW]       = e.tag;
    exu_wdata[i*32 +: 32]     = e.wdata;
    exu_inst_id[i*IW +: IW]   = e.inst_id;
  endtask

  // Broadcast monitor: every asserted lane must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NC; k++) begin
        if (cdb_wr[k]) begin
          cdb_entry_t got;
          cdb_entry_t exp;
          got.tag     = cdb_tag[k*TW +: TW];
          got.wdata   = cdb_wdata[k*32 +: 32];
          got.inst_id = cdb_inst_id[k*IW +: IW];
          total++;
          assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_bcast lane%0d: got %0h expected none", k, got);
          end
          if (sb.size() != 0) begin
            exp = sb.pop_front();
            chk($sformatf("lane%0d_payload", k), 64'(got), 64'(exp));
          end
        end
      end
    end
  end

  initial begin
    cdb_entry_t e;

    // ---- reset state ----
    #12;
    chk("rst_cdb_wr", 64'(cdb_wr), 64'(0));
    chk("rst_rdy", 64'(exu_rdy), 64'(4'hF));
    chk("rst_cdb_wdata", 64'(cdb_wdata), 64'(0));
    #11 rst_n = 1'b1;

    // ---- contention: all four at once, rr_ptr=0 ----
    step();
    for (int i = 0; i < NR; i++) begin
      drive(i, mk(i, 0));
      sb.push_back(mk(i, 0));
    end
    @(negedge clk);
    chk("t2_rdy_accept", 64'(exu_rdy), 64'(4'hF));
    step();
    exu_req = 4'b1100;            // 2,3 keep asking while blocked
    @(negedge clk);
    chk("t2_rdy_c1", 64'(exu_rdy), 64'(4'b0011));
    chk("t2_wr_c1", 64'(cdb_wr), 64'(0));
    step();
    exu_req = '0;
    @(negedge clk);
    chk("t2_wr_c2", 64'(cdb_wr), 64'(2'b11));
    chk("t2_rdy_c2", 64'(exu_rdy), 64'(4'hF));
    step();
    @(negedge clk);
    chk("t2_wr_c3", 64'(cdb_wr), 64'(2'b11));
    step();
    @(negedge clk);
    chk("t2_wr_c4", 64'(cdb_wr), 64'(0));
`ifdef CDB_ARB_PERF_EN
    chk("perf_bcast", 64'(perf_bcast_cnt), 64'(4));
    chk("perf_stall0", 64'(perf_stall_cnt[0 +: 32]), 64'(0));
    chk("perf_stall2", 64'(perf_stall_cnt[64 +: 32]), 64'(1));
    chk("perf_stall3", 64'(perf_stall_cnt[96 +: 32]), 64'(1));
`endif

    // ---- single source ----
    step();
    e.tag = 4'd3; e.wdata = 32'hDEAD_BEEF; e.inst_id = IW'(5);
    drive(0, e);
    sb.push_back(e);
    @(negedge clk);
    step();
    exu_req = '0;
    @(negedge clk);
    chk("t1_wr_c1", 64'(cdb_wr), 64'(0));
    step();
    @(negedge clk);
    chk("t1_wr_c2", 64'(cdb_wr), 64'(2'b01));
    step();
    @(negedge clk);
    chk("t1_wr_c3", 64'(cdb_wr), 64'(0));

    // ---- back-to-back streaming on source 1 ----
    for (int n = 0; n < 12; n++) begin
      step();
      if (n < 10) begin
        e.tag = TW'(n); e.wdata = 32'h0000_1000 + 32'(n); e.inst_id = IW'(n);
        drive(1, e);
        sb.push_back(e);
      end else begin
        exu_req = '0;
      end
      @(negedge clk);
      if (n < 10) chk($sformatf("t3_rdy_%0d", n), 64'(exu_rdy[1]), 64'(1));
      if (n >= 2) chk($sformatf("t3_wr_%0d", n), 64'(cdb_wr), 64'(2'b01));
    end
    step();
    @(negedge clk);
    chk("t3_wr_end", 64'(cdb_wr), 64'(0));

    // ---- flush with two valid entries (rr_ptr=2) ----
    step();
    drive(0, mk(0, 1));
    drive(2, mk(2, 1));
    @(negedge clk);
    step();
    exu_req = '0;
    flush   = 1'b1;
    @(negedge clk);
    chk("t4_rdy_flush", 64'(exu_rdy), 64'(0));
    chk("t4_wr_flush", 64'(cdb_wr), 64'(0));
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("t4_wr_after", 64'(cdb_wr), 64'(0));
    chk("t4_rdy_after", 64'(exu_rdy), 64'(4'hF));
    step();
    @(negedge clk);
    chk("t4_wr_after2", 64'(cdb_wr), 64'(0));
    // rr_ptr must still be 2: order 2,3 then 0,1
    step();
    for (int i = 0; i < NR; i++) drive(i, mk(i, 2));
    sb.push_back(mk(2, 2));
    sb.push_back(mk(3, 2));
    sb.push_back(mk(0, 2));
    sb.push_back(mk(1, 2));
    step();
    exu_req = '0;
    for (int n = 0; n < 3; n++) step();
    @(negedge clk);
    chk("t4_drained", 64'(sb.size()), 64'(0));

    // ---- async reset mid-stream (rr_ptr=2) ----
    step();
    for (int i = 0; i < NR; i++) drive(i, mk(i, 3));
    sb.push_back(mk(2, 3));
    sb.push_back(mk(3, 3));
    step();
    exu_req = '0;
    step();
    @(negedge clk);
    chk("t5_wr_pre", 64'(cdb_wr), 64'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_wr_async", 64'(cdb_wr), 64'(0));
    chk("t5_rdy_async", 64'(exu_rdy), 64'(4'hF));
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      @(negedge clk);
      chk($sformatf("t5_wr_post_%0d", n), 64'(cdb_wr), 64'(0));
    end
    chk("t5_rdy_post", 64'(exu_rdy), 64'(4'hF));
    chk("final_sb_empty", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
